// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and op classification for alu_muldiv
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops that go through the shared iterative datapath instead of finishing in one cycle
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - shared shift-add multiply / restoring divide datapath with iteration counter
module alu_iter
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] hi_next,
  output logic [N-1:0] lo_next
);

  // acc: product high half / partial remainder; sh: multiplier+product low half / dividend+quotient
  logic [N-1:0]     acc;
  logic [N-1:0]     sh;
  logic [N-1:0]     opd;
  logic             div_mode;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0] addend;
  logic [N:0]   add_sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;
  logic         ge;

  // One iteration step: hi_next/lo_next are the register values after this cycle's step
  always_comb begin
    addend  = sh[0] ? opd : '0;
    add_sum = {1'b0, acc} + {1'b0, addend};
    shifted = {acc, sh[N-1]};
    diff    = shifted[N-1:0] - opd;
    ge      = shifted >= {1'b0, opd};
    if (div_mode) begin
      // Divisor zero makes ge always true: quotient all ones, remainder ends up equal to a
      hi_next = ge ? diff : shifted[N-1:0];
      lo_next = {sh[N-2:0], ge};
    end else begin
      hi_next = add_sum[N:1];
      lo_next = {add_sum[0], sh[N-1:1]};
    end
  end

  assign last = (cnt == '0);

  // Operand capture on load, then one step per CALC cycle while counting down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sh       <= '0;
      opd      <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= '0;
      sh       <= is_div ? a : b;
      opd      <= is_div ? b : a;
      div_mode <= is_div;
      cnt      <= CNT_W'(N - 1);
    end else if (step) begin
      acc <= hi_next;
      sh  <= lo_next;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - handshaked ALU with single-cycle logic/arith ops and iterative mul/div
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zerof,
  output logic         busy
);

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   op;
  logic         hs;
  logic         iter_load;
  logic         last;
  logic [N-1:0] hi_next;
  logic [N-1:0] lo_next;
  logic [N-1:0] single_res;
  logic [N-1:0] iter_res;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);
  assign hs        = in_valid && in_ready;
  assign iter_load = hs && is_iter_op(sel);

  // Odd opcodes (MULHU, REMU) take the high/remainder half, even ones the low/quotient half
  assign iter_res  = op[0] ? hi_next : lo_next;

  alu_iter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (iter_load),
    .step    (busy),
    .is_div  (sel[2]),
    .a       (a),
    .b       (b),
    .last    (last),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Single-cycle operation results straight from the request operands
  always_comb begin
    single_res = '0;
    case (sel)
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a + ~b + N'(1);
      OP_SLTU: single_res = {{(N-1){1'b0}}, (a < b)};
      default: single_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; in_valid only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = is_iter_op(sel) ? CALC : DONE;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result and zero flag registered together; held unchanged through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= OP_AND;
      result <= '0;
      zerof  <= 1'b1;
    end else if (hs) begin
      op <= sel;
      if (!is_iter_op(sel)) begin
        result <= single_res;
        zerof  <= (single_res == '0);
      end
    end else if (busy && last) begin
      result <= iter_res;
      zerof  <= (iter_res == '0);
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed table-driven self-checking bench for alu_muldiv
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zerof;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_muldiv #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zerof     (zerof),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        zf;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge, wait (bounded) for out_valid; count in_ready seen high meanwhile
  task automatic run_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int rdy_seen);
    sel      = s;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int rdy_seen;
    logic [31:0] held;

    vecs[0]  = '{OP_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1};
    vecs[1]  = '{OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1};
    vecs[2]  = '{OP_SLTU,  32'd5,         32'd7,         32'h1,         1'b0, 1};
    vecs[3]  = '{OP_SLTU,  32'd7,         32'd5,         32'h0,         1'b1, 1};
    vecs[4]  = '{OP_AND,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1};
    vecs[5]  = '{OP_OR,    32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1};
    vecs[6]  = '{4'b0011,  32'd5,         32'd7,         32'h0,         1'b1, 1};
    vecs[7]  = '{4'b1111,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1};
    vecs[8]  = '{OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1, 33};
    vecs[9]  = '{OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1,         1'b0, 33};
    vecs[10] = '{OP_MUL,   32'h1234,      32'h10,        32'h12340,     1'b0, 33};
    vecs[11] = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[12] = '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 33};
    vecs[13] = '{OP_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 33};
    vecs[14] = '{OP_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 33};
    vecs[15] = '{OP_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[16] = '{OP_REMU,  32'd9,         32'd0,         32'd9,         1'b0, 33};
    vecs[17] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[18] = '{OP_DIVU,  32'd5,         32'd7,         32'h0,         1'b1, 33};
    vecs[19] = '{OP_REMU,  32'd5,         32'd7,         32'd5,         1'b0, 33};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset busy",      {31'b0, busy},      32'h0);
    chk("reset result",    result,             32'h0);
    chk("reset zerof",     {31'b0, zerof},     32'h1);
    rst_n = 1'b1;
    chk("reset in_ready",  {31'b0, in_ready},  32'h1);

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("v%0d in_ready before", i), {31'b0, in_ready}, 32'h1);
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, lat, rdy_seen);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d result", i), result, vecs[i].res);
      chk($sformatf("v%0d zerof", i), {31'b0, zerof}, {31'b0, vecs[i].zf});
      chk($sformatf("v%0d in_ready during op", i), rdy_seen, 0);
      release_result();
    end

    // Back-pressure in DONE: outputs hold, a second request is ignored
    run_op(OP_MUL, 32'd3, 32'd4, lat, rdy_seen);
    chk("stall latency", lat, 33);
    held = result;
    chk("stall result", held, 32'd12);
    sel      = OP_ADD;
    a        = 32'd100;
    b        = 32'd200;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall c%0d out_valid", k), {31'b0, out_valid}, 32'h1);
      chk($sformatf("stall c%0d result", k), result, 32'd12);
      chk($sformatf("stall c%0d in_ready", k), {31'b0, in_ready}, 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("after stall out_valid", {31'b0, out_valid}, 32'h0);
    chk("after stall in_ready", {31'b0, in_ready}, 32'h1);
    run_op(OP_ADD, 32'd10, 32'd20, lat, rdy_seen);
    chk("post-stall latency", lat, 1);
    chk("post-stall result", result, 32'd30);
    release_result();

    // Asynchronous reset in the middle of a divide
    sel      = OP_DIVU;
    a        = 32'd1000;
    b        = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid-calc busy", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst busy",      {31'b0, busy},      32'h0);
    chk("mid rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid rst result",    result,             32'h0);
    chk("mid rst zerof",     {31'b0, zerof},     32'h1);
    chk("mid rst in_ready",  {31'b0, in_ready},  32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post rst in_ready", {31'b0, in_ready}, 32'h1);
    run_op(OP_ADD, 32'd2, 32'd3, lat, rdy_seen);
    chk("post rst add latency", lat, 1);
    chk("post rst add result", result, 32'd5);
    chk("post rst add zerof", {31'b0, zerof}, 32'h0);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter N, default 32, operand/result width in bits (N >= 4, even).
REQ-002 Parameter CNT_W, default $clog2(N)+1, iteration counter width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request carries valid a, b, sel.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  N  operand A.
REQ-008 b  input  N  operand B.
REQ-009 sel  input  4  operation select.
REQ-010 out_valid  output  1  result and zerof valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  N  registered operation result.
REQ-013 zerof  output  1  registered flag, 1 when result == 0.
REQ-014 busy  output  1  high in CALC state.

Function
REQ-015 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU, 1000 MUL (low N bits), 1001 MULHU (high N bits, unsigned), 1100 DIVU, 1101 REMU; any other code yields result 0.
REQ-016 ADD/SUB SHALL wrap modulo 2^N; SUB computed as a + ~b + 1; carry out discarded.
REQ-017 SLTU SHALL yield 1 when a < b unsigned, else 0.
REQ-018 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-019 in_ready SHALL be 1 only in IDLE; handshake occurs when in_valid && in_ready; operands and sel captured on that edge.
REQ-020 Single-cycle ops (AND, OR, ADD, SUB, SLTU, undefined): IDLE -> DONE on handshake; out_valid high the next cycle (latency 1).
REQ-021 MUL/MULHU/DIVU/REMU: IDLE -> CALC on handshake; exactly N CALC cycles (counter N-1 down to 0) then DONE; out_valid high N+1 cycles after handshake.
REQ-022 Multiply SHALL be iterative unsigned shift-add over a 2N-bit product register, one multiplier bit per cycle.
REQ-023 Divide SHALL be iterative unsigned restoring division, one quotient bit per cycle.
REQ-024 Divide by zero SHALL produce quotient 2^N-1 and remainder a, same latency, no error flag.
REQ-025 In DONE, result, zerof, out_valid SHALL hold stable until out_valid && out_ready; then DONE -> IDLE the following edge.
REQ-026 No new request SHALL be accepted in the cycle DONE is left (in_ready rises one cycle later).
REQ-027 in_valid changes while in CALC or DONE SHALL be ignored.
REQ-028 zerof SHALL be computed from the final result and registered with it.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out_valid 0, busy 0, result 0, zerof 1, counter 0, including mid-CALC; partial computation discarded.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 at the first rising edge.

Structure
REQ-031 Shared package alu_pkg SHALL hold opcode constants and the IDLE/CALC/DONE state encoding.
REQ-032 One sub-module alu_iter SHALL hold the shared shift-add/restoring-divide datapath and counter; ALU ops and FSM stay in alu_muldiv.

Verification
REQ-033 N=32, ADD a=0xFFFFFFFF b=1 -> result 0, zerof 1, out_valid 1 cycle after handshake.
REQ-034 SUB a=5 b=7 -> 0xFFFFFFFE, zerof 0; SLTU a=5 b=7 -> 1.
REQ-035 MUL a=0x10000 b=0x10000 -> 0; MULHU same -> 1; out_valid exactly 33 cycles after handshake, in_ready 0 throughout.
REQ-036 DIVU a=100 b=7 -> 14; REMU -> 2; DIVU a=9 b=0 -> 0xFFFFFFFF; REMU a=9 b=0 -> 9.
REQ-037 out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, second in_valid ignored; out_ready 1 -> IDLE, new request accepted next cycle.
REQ-038 rst_n pulsed low at CALC cycle 10 of DIVU -> outputs at reset values immediately; fresh ADD 2+3 afterwards returns 5.
